// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 8-bit registered ALU:
//   - DATA_W   : operand / result width
//   - OP_W     : opcode width
//   - opcode_e : operation encoding driven on the `control` input
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'h0,
        OP_SUB = 3'h1,
        OP_MUL = 3'h2,
        OP_AND = 3'h3,
        OP_OR  = 3'h4,
        OP_XOR = 3'h5,
        OP_SHL = 3'h6,
        OP_SHR = 3'h7
    } opcode_e;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU datapath. Produces the next-state values that the
// top level registers.
//   a, b     : in  [7:0] unsigned operands
//   control  : in  [2:0] opcode (alu_pkg::opcode_e)
//   result_d : out [7:0] next result
//   carry_d  : out       next carry / borrow / multiply-overflow flag
//   zero_d   : out       next zero flag (result_d == 0)
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   control,
    output logic [DATA_W-1:0] result_d,
    output logic              carry_d,
    output logic              zero_d
);

    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [2*DATA_W-1:0] prod;
    opcode_e             op;

    assign op = opcode_e'(control);

    // Zero-extended 9-bit arithmetic: bit 8 of the sum is the carry-out and
    // bit 8 of the difference is set exactly when a < b (borrow).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        unique case (op)
            OP_ADD: begin
                result_d = sum[DATA_W-1:0];
                carry_d  = sum[DATA_W];
            end
            OP_SUB: begin
                result_d = diff[DATA_W-1:0];
                carry_d  = diff[DATA_W];
            end
            OP_MUL: begin
                result_d = prod[DATA_W-1:0];
                carry_d  = |prod[2*DATA_W-1:DATA_W];
            end
            OP_AND: result_d = a & b;
            OP_OR:  result_d = a | b;
            OP_XOR: result_d = a ^ b;
            OP_SHL: begin
                result_d = {a[DATA_W-2:0], 1'b0};
                carry_d  = a[DATA_W-1];
            end
            OP_SHR: begin
                result_d = {1'b0, a[DATA_W-1:1]};
                carry_d  = a[0];
            end
            default: begin
                result_d = '0;
                carry_d  = 1'b0;
            end
        endcase
    end

    // Derived from the same-cycle result so the registered flag always
    // agrees with the registered result.
    assign zero_d = (result_d == '0);

endmodule : alu_core

// File: rtl/alu_8bit.sv
// -----------------------------------------------------------------------------
// alu_8bit
// Registered 8-bit ALU: operands and opcode are sampled every rising edge and
// the result and flags appear one cycle later. No handshake.
//   clk     : in        rising-edge clock
//   rst     : in        asynchronous active-high reset
//   a, b    : in  [7:0] unsigned operands
//   control : in  [2:0] opcode (alu_pkg::opcode_e)
//   result  : out [7:0] registered result
//   carry   : out       registered carry / borrow / multiply-overflow flag
//   zero    : out       registered zero flag (1 when result == 0)
// -----------------------------------------------------------------------------
module alu_8bit
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   control,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W-1:0] result_d, result_q;
    logic              carry_d,  carry_q;
    logic              zero_d,   zero_q;

    alu_core u_core (
        .a        (a),
        .b        (b),
        .control  (control),
        .result_d (result_d),
        .carry_d  (carry_d),
        .zero_d   (zero_d)
    );

    // Reset state is result 0 with zero=1, so the flags stay self-consistent
    // even before the first operation is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;

endmodule : alu_8bit

// File: tb/tb_alu_8bit.sv
// -----------------------------------------------------------------------------
// tb_alu_8bit
// Scoreboard bench for alu_8bit: the driver applies directed vectors on the
// falling edge and pushes the hand-computed response; the monitor pops one
// entry per rising edge and compares the registered outputs.
// -----------------------------------------------------------------------------
module tb_alu_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] control;
    logic [7:0] result;
    logic       carry;
    logic       zero;

    typedef struct packed {
        logic [7:0] res;
        logic       cy;
        logic       zf;
        logic [7:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    alu_8bit dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .control (control),
        .result  (result),
        .carry   (carry),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] r, input logic c,
                         input logic z, input logic [7:0] er, input logic ec,
                         input logic ez);
        total_cnt++;
        if (r === er && c === ec && z === ez) begin
            pass_cnt++;
            $display("ok   %-14s result=%02h carry=%0b zero=%0b", name, r, c, z);
        end else begin
            $display("FAIL %-14s got result=%02h carry=%0b zero=%0b, expected result=%02h carry=%0b zero=%0b",
                     name, r, c, z, er, ec, ez);
        end
    endtask

    // Apply one operation on the falling edge; its response is due after the
    // next rising edge.
    task automatic step(input logic [2:0] op, input logic [7:0] va,
                        input logic [7:0] vb, input logic [7:0] er,
                        input logic ec, input logic [7:0] tag);
        exp_t e;
        @(negedge clk);
        control = op;
        a       = va;
        b       = vb;
        e.res   = er;
        e.cy    = ec;
        e.zf    = (er == 8'h00);
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: one pop per rising edge whenever a response is outstanding.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("vec%0d", e.tag), result, carry, zero, e.res, e.cy, e.zf);
            end
        end
    end

    initial begin
        int wait_cyc;
        rst     = 1'b0;
        a       = 8'h00;
        b       = 8'h00;
        control = 3'h0;

        // Asynchronous reset with no clock edge in between (clk rises at 5).
        #1 rst = 1'b1;
        #2 check("rst_async", result, carry, zero, 8'h00, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1 check("rst_hold", result, carry, zero, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // tag, expected values hand-computed
        step(3'h0, 8'hAA, 8'h11, 8'hBB, 1'b0, 0);   // ADD first after reset
        step(3'h0, 8'hAA, 8'h60, 8'h0A, 1'b1, 1);   // ADD carry out
        step(3'h1, 8'h05, 8'h01, 8'h04, 1'b0, 2);   // SUB no borrow
        step(3'h1, 8'h01, 8'h05, 8'hFC, 1'b1, 3);   // SUB borrow
        step(3'h2, 8'h05, 8'h01, 8'h05, 1'b0, 4);   // MUL
        step(3'h2, 8'h20, 8'h10, 8'h00, 1'b1, 5);   // MUL 0x200: overflow, zero
        step(3'h3, 8'hAA, 8'h11, 8'h00, 1'b0, 6);   // AND -> zero
        step(3'h4, 8'hAA, 8'h11, 8'hBB, 1'b0, 7);   // OR
        step(3'h5, 8'hAA, 8'h11, 8'hBB, 1'b0, 8);   // XOR
        step(3'h6, 8'hAA, 8'h11, 8'h54, 1'b1, 9);   // SHL
        step(3'h6, 8'hAA, 8'hFF, 8'h54, 1'b1, 10);  // SHL, b ignored
        step(3'h7, 8'hAA, 8'h11, 8'h55, 1'b0, 11);  // SHR
        step(3'h7, 8'hAA, 8'h00, 8'h55, 1'b0, 12);  // SHR, b ignored
        step(3'h7, 8'h01, 8'h00, 8'h00, 1'b1, 13);  // SHR shifts out bit 0

        // Back-to-back sweep of every opcode with a=AA, b=11
        step(3'h0, 8'hAA, 8'h11, 8'hBB, 1'b0, 20);
        step(3'h1, 8'hAA, 8'h11, 8'h99, 1'b0, 21);
        step(3'h2, 8'hAA, 8'h11, 8'h4A, 1'b1, 22);  // 0x0B4A
        step(3'h3, 8'hAA, 8'h11, 8'h00, 1'b0, 23);
        step(3'h4, 8'hAA, 8'h11, 8'hBB, 1'b0, 24);
        step(3'h5, 8'hAA, 8'h11, 8'hBB, 1'b0, 25);
        step(3'h6, 8'hAA, 8'h11, 8'h54, 1'b1, 26);
        step(3'h7, 8'hAA, 8'h11, 8'h55, 1'b0, 27);

        // Mid-stream reset: ADD AA+60 is in flight when rst rises between edges.
        @(negedge clk);
        control = 3'h0;
        a       = 8'hAA;
        b       = 8'h60;
        #2 rst = 1'b1;
        #1 check("rst_midstream", result, carry, zero, 8'h00, 1'b0, 1'b1);
        @(posedge clk);
        #1 check("rst_mid_hold", result, carry, zero, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        step(3'h0, 8'hAA, 8'h60, 8'h0A, 1'b1, 30);  // stream resumes
        step(3'h1, 8'h10, 8'h10, 8'h00, 1'b0, 31);  // SUB equal -> zero, no borrow
        step(3'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 32);  // ADD wrap -> zero with carry

        // Drain, bounded by a cycle budget.
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (exp_q.size() > 0) begin
            total_cnt++;
            $display("FAIL drain_timeout outstanding=%0d required=0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_alu_8bit
